sdio_cmd: RTL and testbench
===========================

Name: sdio_cmd

Overview:
- Command-line engine of the SD host.
- Serialises a 48-bit command frame onto CMD, waits for and deserialises the 48-bit or 136-bit card response, and checks CRC7, end bit and index.
- Publishes response fields, busy/FSM state, completion pulse and error flags to the register block, which reads them through its status and response registers.
- Sits between the register block (upstream: argument, index, response type, check enables) and the CMD pad.

Parameters:
NCR_MAX, 64, rx bit strobes allowed between end of command and response start bit before timeout
NCC_CYCLES, 8, tx bit strobes of idle (CMD high, released) after each transaction

Ports:
sd_clk  in  1  block clock
rstn  in  1  reset
cmd_sd_rst  in  1  synchronous soft reset, level
tx_en  in  1  one-cycle strobe: launch next CMD output bit
rx_en  in  1  one-cycle strobe: sample pad_cmd_i
cmd_start  in  1  one-cycle pulse: start transaction
cmd_index  in  6  command index
cmd_argument  in  32  command argument
resp_type  in  2  0 none, 1 136-bit, 2/3 48-bit
cmd_index_check  in  1  enable index compare
cmd_crc_check  in  1  enable CRC compare
pad_cmd_i  in  1  CMD pad input
pad_cmd_o  out  1  CMD pad output
pad_cmd_oe  out  1  CMD pad output enable
resp  out  120  response payload
resp_index  out  6  response index / R2 reserved field
resp_crc  out  7  received CRC7
cmd_busy  out  1  transaction in progress
cmd_fsm  out  4  state encoding
cmd_complete  out  1  one-cycle completion pulse
cmd_timeout_err, cmd_crc_err, cmd_end_err, cmd_index_err  out  1 each  sticky error flags

Behaviour:
- Reset: rstn is asynchronous, active-low; clock is sd_clk. All outputs are 0 except pad_cmd_o=1.
- cmd_sd_rst has the same effect as reset, applied synchronously.
- States and cmd_fsm encoding: IDLE=0, TX=1, WAIT=2, RX=3, CHECK=4, NCC=5. cmd_busy = (state != IDLE).
- IDLE:
  - cmd_start latches cmd_index, cmd_argument, resp_type and both check enables.
  - The same cmd_start clears all four error flags; next state is TX.
  - cmd_start in any other state is ignored.
- TX:
  - pad_cmd_oe=1. Frame = {0, 1, index[5:0], arg[31:0], crc7[6:0], 1}, MSB first.
  - CRC7: polynomial x^7+x^3+1, init 0, covers the first 40 bits.
  - pad_cmd_o is 1 until the first tx_en; each tx_en drives the next bit.
  - The tx_en after the end bit sets pad_cmd_oe=0 and pad_cmd_o=1. Next state is NCC if resp_type==0 (cmd_complete pulses on entry), else WAIT.
- WAIT:
  - On each rx_en: pad_cmd_i==0 -> RX (start bit consumed); otherwise increment the counter.
  - Counter reaching NCR_MAX -> cmd_timeout_err=1, cmd_complete pulse, go to NCC. Response outputs are unchanged.
- RX:
  - Shift in 47 (48-bit) or 135 (136-bit) further bits on rx_en, then go to CHECK.
  - CRC7 accumulates over the bits after the start bit:
    - 48-bit: 39 bits, tx bit through payload.
    - 136-bit: 120 bits of the [127:8] field only.
- CHECK (single cycle):
  - 48-bit: resp[119:32]=0, resp[31:0]=payload, resp_index=index field.
  - 136-bit: resp=field[127:8], resp_index=reserved field.
  - resp_crc=received CRC.
  - cmd_end_err = end bit==0.
  - cmd_crc_err = cmd_crc_check && CRC mismatch.
  - cmd_index_err = cmd_index_check && 48-bit && resp_index!=latched index. Never set for 136-bit.
  - Pulse cmd_complete; go to NCC.
- Response outputs change only in CHECK, so they are stable for register reads at all other times.
- NCC: count NCC_CYCLES tx_en strobes with CMD released, then IDLE.
- A tx_en and rx_en in the same cycle are both honoured; only the one relevant to the current state acts.

Test Plan:
- CMD0, arg 0, resp_type 0: CMD bitstream equals 0x400000000095 MSB first, oe high exactly 48 tx_en periods → cmd_complete one cycle after release; cmd_busy falls after 8 further tx_en; no error flags.
- CMD8, arg 0x000001AA, resp_type 2, both checks on: TX equals 0x48000001AA87; card drives 0x08000001AA13 after 5 rx_en → resp[31:0]=0x000001AA, resp_index=8, resp_crc=0x09, no errors.
- Same as previous with response CRC byte 0x15 → cmd_crc_err=1; with cmd_crc_check=0 → no error. Response index 9 → cmd_index_err=1.
- Card never drives start bit → cmd_timeout_err=1 after exactly 64 rx_en, resp unchanged, cmd_complete pulse once.
- R2 (resp_type 1), card sends 136 bits with valid CRC → resp equals transmitted [127:8], resp_index=0x3F, no index error even with check on; end bit forced 0 → cmd_end_err=1.
- cmd_sd_rst asserted mid-RX → next cycle IDLE, oe=0, flags cleared; second cmd_start during TX ignored, frame unaffected.

Source files
------------

// File: rtl/sdio_cmd_if.sv
// Bundles the register-block controls, the bit strobes, the CMD pad pins and the status/response outputs of the SD command engine.
interface sdio_cmd_if;
  logic         tx_en;
  logic         rx_en;
  logic         cmd_start;
  logic [5:0]   cmd_index;
  logic [31:0]  cmd_argument;
  logic [1:0]   resp_type;
  logic         cmd_index_check;
  logic         cmd_crc_check;
  logic         pad_cmd_i;
  logic         pad_cmd_o;
  logic         pad_cmd_oe;
  logic [119:0] resp;
  logic [5:0]   resp_index;
  logic [6:0]   resp_crc;
  logic         cmd_busy;
  logic [3:0]   cmd_fsm;
  logic         cmd_complete;
  logic         cmd_timeout_err;
  logic         cmd_crc_err;
  logic         cmd_end_err;
  logic         cmd_index_err;

  modport slave (
    input  tx_en, rx_en, cmd_start, cmd_index, cmd_argument, resp_type,
           cmd_index_check, cmd_crc_check, pad_cmd_i,
    output pad_cmd_o, pad_cmd_oe, resp, resp_index, resp_crc, cmd_busy, cmd_fsm,
           cmd_complete, cmd_timeout_err, cmd_crc_err, cmd_end_err, cmd_index_err
  );

  modport master (
    output tx_en, rx_en, cmd_start, cmd_index, cmd_argument, resp_type,
           cmd_index_check, cmd_crc_check, pad_cmd_i,
    input  pad_cmd_o, pad_cmd_oe, resp, resp_index, resp_crc, cmd_busy, cmd_fsm,
           cmd_complete, cmd_timeout_err, cmd_crc_err, cmd_end_err, cmd_index_err
  );
endinterface

// File: rtl/sdio_cmd.sv
// SD CMD-line engine: serialises a 48-bit command, receives a 48/136-bit response,
// checks CRC7, end bit and index, and holds response/status for the register block.
module sdio_cmd #(
  parameter int NCR_MAX    = 64,
  parameter int NCC_CYCLES = 8
) (
  input  logic sd_clk,
  input  logic rstn,
  input  logic cmd_sd_rst,
  sdio_cmd_if.slave bus
);
  localparam int NCR_W = (NCR_MAX > 1) ? $clog2(NCR_MAX) : 1;
  localparam int NCC_W = (NCC_CYCLES > 1) ? $clog2(NCC_CYCLES) : 1;
  localparam logic [NCR_W-1:0] NCR_LAST = NCR_W'(NCR_MAX - 1);
  localparam logic [NCC_W-1:0] NCC_LAST = NCC_W'(NCC_CYCLES - 1);

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0, ST_TX = 4'd1, ST_WAIT = 4'd2,
    ST_RX = 4'd3, ST_CHECK = 4'd4, ST_NCC = 4'd5
  } state_t;

  state_t           state_q, state_d;
  logic [5:0]       tx_cnt_q, tx_cnt_d;
  logic [39:0]      tx_sr_q, tx_sr_d;
  logic [6:0]       crc_q, crc_d;
  logic [7:0]       rx_cnt_q, rx_cnt_d;
  logic [133:0]     rx_sr_q, rx_sr_d;
  logic [NCR_W-1:0] ncr_cnt_q, ncr_cnt_d;
  logic [NCC_W-1:0] ncc_cnt_q, ncc_cnt_d;
  logic [5:0]       idx_q, idx_d;
  logic [1:0]       rtype_q, rtype_d;
  logic             ichk_q, ichk_d, cchk_q, cchk_d;
  logic             pad_o_q, pad_o_d, pad_oe_q, pad_oe_d;
  logic [119:0]     resp_q, resp_d;
  logic [5:0]       resp_index_q, resp_index_d;
  logic [6:0]       resp_crc_q, resp_crc_d;
  logic             complete_q, complete_d;
  logic             tout_err_q, tout_err_d, crc_err_q, crc_err_d;
  logic             end_err_q, end_err_d, idx_err_q, idx_err_d;
  logic             is48;
  logic             rx_crc_bit;

  function automatic logic [6:0] crc7_next(input logic [6:0] c, input logic b);
    logic fb;
    fb = b ^ c[6];
    return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  // Response types 2 and 3 are both short (48-bit) responses.
  assign is48 = rtype_q[1];
  // Short responses cover tx bit..payload; R2 covers only the [127:8] field.
  assign rx_crc_bit = is48 ? (rx_cnt_q < 8'd39) : ((rx_cnt_q >= 8'd7) && (rx_cnt_q < 8'd127));

  always_ff @(posedge sd_clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      tx_cnt_q     <= '0;
      tx_sr_q      <= '0;
      crc_q        <= '0;
      rx_cnt_q     <= '0;
      rx_sr_q      <= '0;
      ncr_cnt_q    <= '0;
      ncc_cnt_q    <= '0;
      idx_q        <= '0;
      rtype_q      <= '0;
      ichk_q       <= 1'b0;
      cchk_q       <= 1'b0;
      pad_o_q      <= 1'b1;
      pad_oe_q     <= 1'b0;
      resp_q       <= '0;
      resp_index_q <= '0;
      resp_crc_q   <= '0;
      complete_q   <= 1'b0;
      tout_err_q   <= 1'b0;
      crc_err_q    <= 1'b0;
      end_err_q    <= 1'b0;
      idx_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      tx_cnt_q     <= tx_cnt_d;
      tx_sr_q      <= tx_sr_d;
      crc_q        <= crc_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_sr_q      <= rx_sr_d;
      ncr_cnt_q    <= ncr_cnt_d;
      ncc_cnt_q    <= ncc_cnt_d;
      idx_q        <= idx_d;
      rtype_q      <= rtype_d;
      ichk_q       <= ichk_d;
      cchk_q       <= cchk_d;
      pad_o_q      <= pad_o_d;
      pad_oe_q     <= pad_oe_d;
      resp_q       <= resp_d;
      resp_index_q <= resp_index_d;
      resp_crc_q   <= resp_crc_d;
      complete_q   <= complete_d;
      tout_err_q   <= tout_err_d;
      crc_err_q    <= crc_err_d;
      end_err_q    <= end_err_d;
      idx_err_q    <= idx_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    tx_cnt_d     = tx_cnt_q;
    tx_sr_d      = tx_sr_q;
    crc_d        = crc_q;
    rx_cnt_d     = rx_cnt_q;
    rx_sr_d      = rx_sr_q;
    ncr_cnt_d    = ncr_cnt_q;
    ncc_cnt_d    = ncc_cnt_q;
    idx_d        = idx_q;
    rtype_d      = rtype_q;
    ichk_d       = ichk_q;
    cchk_d       = cchk_q;
    pad_o_d      = pad_o_q;
    pad_oe_d     = pad_oe_q;
    resp_d       = resp_q;
    resp_index_d = resp_index_q;
    resp_crc_d   = resp_crc_q;
    complete_d   = 1'b0;
    tout_err_d   = tout_err_q;
    crc_err_d    = crc_err_q;
    end_err_d    = end_err_q;
    idx_err_d    = idx_err_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_start) begin
          idx_d      = bus.cmd_index;
          rtype_d    = bus.resp_type;
          ichk_d     = bus.cmd_index_check;
          cchk_d     = bus.cmd_crc_check;
          tx_sr_d    = {2'b01, bus.cmd_index, bus.cmd_argument};
          tx_cnt_d   = '0;
          crc_d      = '0;
          rx_cnt_d   = '0;
          ncr_cnt_d  = '0;
          ncc_cnt_d  = '0;
          tout_err_d = 1'b0;
          crc_err_d  = 1'b0;
          end_err_d  = 1'b0;
          idx_err_d  = 1'b0;
          pad_oe_d   = 1'b1;
          pad_o_d    = 1'b1;
          state_d    = ST_TX;
        end
      end
      ST_TX: begin
        if (bus.tx_en) begin
          tx_cnt_d = tx_cnt_q + 6'd1;
          if (tx_cnt_q < 6'd40) begin
            pad_o_d = tx_sr_q[39];
            tx_sr_d = {tx_sr_q[38:0], 1'b0};
            crc_d   = crc7_next(crc_q, tx_sr_q[39]);
          end else if (tx_cnt_q < 6'd47) begin
            pad_o_d = crc_q[6];
            crc_d   = {crc_q[5:0], 1'b0};
          end else if (tx_cnt_q == 6'd47) begin
            pad_o_d = 1'b1;
          end else begin
            // Release the line; the CRC register is reused for the response.
            tx_cnt_d = tx_cnt_q;
            pad_oe_d = 1'b0;
            pad_o_d  = 1'b1;
            crc_d    = '0;
            if (rtype_q == 2'd0) begin
              complete_d = 1'b1;
              state_d    = ST_NCC;
            end else begin
              state_d = ST_WAIT;
            end
          end
        end
      end
      ST_WAIT: begin
        if (bus.rx_en) begin
          if (!bus.pad_cmd_i) begin
            state_d = ST_RX;
          end else if (ncr_cnt_q == NCR_LAST) begin
            tout_err_d = 1'b1;
            complete_d = 1'b1;
            state_d    = ST_NCC;
          end else begin
            ncr_cnt_d = ncr_cnt_q + 1'b1;
          end
        end
      end
      ST_RX: begin
        if (bus.rx_en) begin
          rx_sr_d = {rx_sr_q[132:0], bus.pad_cmd_i};
          if (rx_crc_bit) crc_d = crc7_next(crc_q, bus.pad_cmd_i);
          if (rx_cnt_q == (is48 ? 8'd46 : 8'd134)) state_d = ST_CHECK;
          else rx_cnt_d = rx_cnt_q + 8'd1;
        end
      end
      ST_CHECK: begin
        if (is48) begin
          resp_d       = {88'd0, rx_sr_q[39:8]};
          resp_index_d = rx_sr_q[45:40];
          idx_err_d    = ichk_q && (rx_sr_q[45:40] != idx_q);
        end else begin
          resp_d       = rx_sr_q[127:8];
          resp_index_d = rx_sr_q[133:128];
        end
        resp_crc_d = rx_sr_q[7:1];
        end_err_d  = ~rx_sr_q[0];
        crc_err_d  = cchk_q && (crc_q != rx_sr_q[7:1]);
        complete_d = 1'b1;
        state_d    = ST_NCC;
      end
      ST_NCC: begin
        if (bus.tx_en) begin
          if (ncc_cnt_q == NCC_LAST) state_d = ST_IDLE;
          else ncc_cnt_d = ncc_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (cmd_sd_rst) begin
      state_d      = ST_IDLE;
      tx_cnt_d     = '0;
      tx_sr_d      = '0;
      crc_d        = '0;
      rx_cnt_d     = '0;
      rx_sr_d      = '0;
      ncr_cnt_d    = '0;
      ncc_cnt_d    = '0;
      idx_d        = '0;
      rtype_d      = '0;
      ichk_d       = 1'b0;
      cchk_d       = 1'b0;
      pad_o_d      = 1'b1;
      pad_oe_d     = 1'b0;
      resp_d       = '0;
      resp_index_d = '0;
      resp_crc_d   = '0;
      complete_d   = 1'b0;
      tout_err_d   = 1'b0;
      crc_err_d    = 1'b0;
      end_err_d    = 1'b0;
      idx_err_d    = 1'b0;
    end
  end

  assign bus.pad_cmd_o       = pad_o_q;
  assign bus.pad_cmd_oe      = pad_oe_q;
  assign bus.resp            = resp_q;
  assign bus.resp_index      = resp_index_q;
  assign bus.resp_crc        = resp_crc_q;
  assign bus.cmd_busy        = (state_q != ST_IDLE);
  assign bus.cmd_fsm         = state_q;
  assign bus.cmd_complete    = complete_q;
  assign bus.cmd_timeout_err = tout_err_q;
  assign bus.cmd_crc_err     = crc_err_q;
  assign bus.cmd_end_err     = end_err_q;
  assign bus.cmd_index_err   = idx_err_q;
endmodule

// File: tb/tb_sdio_cmd.sv
// Directed bench for sdio_cmd: drives commands, plays a card on the CMD line, checks frames and status.
module tb_sdio_cmd;
  logic sd_clk = 1'b0;
  logic rstn = 1'b0;
  logic cmd_sd_rst = 1'b0;
  logic card_bit = 1'b1;
  int n_checks = 0;
  int n_fail = 0;
  logic [47:0] cap;
  int oe_hi;

  sdio_cmd_if ifc();
  assign ifc.pad_cmd_i = ifc.pad_cmd_oe ? ifc.pad_cmd_o : card_bit;

  sdio_cmd #(.NCR_MAX(64), .NCC_CYCLES(8)) dut (
    .sd_clk(sd_clk), .rstn(rstn), .cmd_sd_rst(cmd_sd_rst), .bus(ifc.slave)
  );

  always #5 sd_clk = ~sd_clk;

  task automatic tick();
    @(posedge sd_clk);
    #1;
  endtask

  function automatic logic [6:0] crc7_bits(input logic [119:0] d);
    logic [6:0] c;
    logic fb;
    c = '0;
    for (int i = 119; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  task automatic start_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rt,
                           input logic ichk, input logic cchk);
    ifc.cmd_index = idx;
    ifc.cmd_argument = arg;
    ifc.resp_type = rt;
    ifc.cmd_index_check = ichk;
    ifc.cmd_crc_check = cchk;
    ifc.cmd_start = 1'b1;
    tick();
    ifc.cmd_start = 1'b0;
  endtask

  // 48 bit strobes captured into cap, then the releasing strobe; optional ignored start at inject_at.
  task automatic do_tx(input int inject_at);
    cap = '0;
    oe_hi = 0;
    for (int i = 0; i < 48; i++) begin
      if (i == inject_at) begin
        ifc.cmd_index = 6'd55;
        ifc.cmd_argument = 32'hFFFF_FFFF;
        ifc.resp_type = 2'd2;
        ifc.cmd_start = 1'b1;
      end
      ifc.tx_en = 1'b1;
      tick();
      ifc.tx_en = 1'b0;
      ifc.cmd_start = 1'b0;
      cap = {cap[46:0], ifc.pad_cmd_o};
      if (ifc.pad_cmd_oe) oe_hi++;
    end
    ifc.tx_en = 1'b1;
    tick();
    ifc.tx_en = 1'b0;
  endtask

  task automatic rx_bit(input logic b);
    card_bit = b;
    ifc.rx_en = 1'b1;
    tick();
    ifc.rx_en = 1'b0;
  endtask

  task automatic card_send(input logic [135:0] frame, input int nbits, input int delay);
    for (int i = 0; i < delay; i++) rx_bit(1'b1);
    for (int i = nbits - 1; i >= 0; i--) rx_bit(frame[i]);
    card_bit = 1'b1;
  endtask

  task automatic finish_ncc(output logic b7, output logic b8);
    for (int i = 0; i < 7; i++) begin
      ifc.tx_en = 1'b1;
      tick();
      ifc.tx_en = 1'b0;
    end
    b7 = ifc.cmd_busy;
    ifc.tx_en = 1'b1;
    tick();
    ifc.tx_en = 1'b0;
    b8 = ifc.cmd_busy;
  endtask

  // Full short-response transaction; returns one cycle after CHECK (first NCC cycle).
  task automatic run_r1(input logic [5:0] idx, input logic [31:0] arg, input logic ichk,
                        input logic cchk, input logic [47:0] card, input int delay);
    start_cmd(idx, arg, 2'd2, ichk, cchk);
    do_tx(-1);
    card_send({88'd0, card}, 48, delay);
    tick();
    $display("txn: CMD%0d arg=%h card=%h resp=%h idx=%0d crc=%h err(t/c/e/i)=%b%b%b%b", idx, arg,
             card, ifc.resp[31:0], ifc.resp_index, ifc.resp_crc, ifc.cmd_timeout_err,
             ifc.cmd_crc_err, ifc.cmd_end_err, ifc.cmd_index_err);
  endtask

  task automatic test_reset();
    logic [11:0] got;
    got = {ifc.pad_cmd_o, ifc.pad_cmd_oe, ifc.cmd_busy, ifc.cmd_complete, ifc.cmd_fsm,
           ifc.cmd_timeout_err, ifc.cmd_crc_err, ifc.cmd_end_err, ifc.cmd_index_err};
    n_checks++;
    if (got !== 12'b1000_0000_0000) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 100000000000", got);
    end
    n_checks++;
    if ({ifc.resp, ifc.resp_index, ifc.resp_crc} !== 133'd0) begin
      n_fail++; $display("FAIL reset_resp: got %h want 0", ifc.resp);
    end
  endtask

  task automatic test_cmd0();
    logic b7, b8;
    start_cmd(6'd0, 32'd0, 2'd0, 1'b0, 1'b0);
    n_checks++;
    if ({ifc.cmd_fsm, ifc.pad_cmd_oe, ifc.pad_cmd_o} !== {4'd1, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL cmd0_tx_entry: fsm=%0d oe=%b o=%b want 1/1/1", ifc.cmd_fsm, ifc.pad_cmd_oe, ifc.pad_cmd_o);
    end
    do_tx(-1);
    $display("txn: CMD0 frame=%h oe_bits=%0d", cap, oe_hi);
    n_checks++;
    if (cap !== 48'h400000000095) begin
      n_fail++; $display("FAIL cmd0_frame: got %h want 400000000095", cap);
    end
    n_checks++;
    if (oe_hi !== 48) begin
      n_fail++; $display("FAIL cmd0_oe_len: got %0d want 48", oe_hi);
    end
    n_checks++;
    if ({ifc.pad_cmd_oe, ifc.pad_cmd_o, ifc.cmd_complete, ifc.cmd_fsm} !== {1'b0, 1'b1, 1'b1, 4'd5}) begin
      n_fail++; $display("FAIL cmd0_release: oe=%b o=%b cpl=%b fsm=%0d want 0/1/1/5",
                         ifc.pad_cmd_oe, ifc.pad_cmd_o, ifc.cmd_complete, ifc.cmd_fsm);
    end
    tick();
    n_checks++;
    if (ifc.cmd_complete !== 1'b0) begin
      n_fail++; $display("FAIL cmd0_cpl_pulse: got %b want 0", ifc.cmd_complete);
    end
    finish_ncc(b7, b8);
    n_checks++;
    if ({b7, b8} !== 2'b10) begin
      n_fail++; $display("FAIL cmd0_ncc_busy: got %b want 10", {b7, b8});
    end
    n_checks++;
    if ({ifc.cmd_timeout_err, ifc.cmd_crc_err, ifc.cmd_end_err, ifc.cmd_index_err} !== 4'b0) begin
      n_fail++; $display("FAIL cmd0_errs: got %b want 0000",
                         {ifc.cmd_timeout_err, ifc.cmd_crc_err, ifc.cmd_end_err, ifc.cmd_index_err});
    end
  endtask

  task automatic test_cmd8();
    logic b7, b8;
    run_r1(6'd8, 32'h0000_01AA, 1'b1, 1'b1, 48'h08000001AA13, 5);
    n_checks++;
    if (cap !== 48'h48000001AA87) begin
      n_fail++; $display("FAIL cmd8_frame: got %h want 48000001AA87", cap);
    end
    n_checks++;
    if ({ifc.resp, ifc.resp_index, ifc.resp_crc} !== {120'h1AA, 6'd8, 7'h09}) begin
      n_fail++; $display("FAIL cmd8_resp: got %h/%0d/%h want 1aa/8/09", ifc.resp, ifc.resp_index, ifc.resp_crc);
    end
    n_checks++;
    if ({ifc.cmd_complete, ifc.cmd_fsm, ifc.cmd_timeout_err, ifc.cmd_crc_err, ifc.cmd_end_err, ifc.cmd_index_err}
        !== {1'b1, 4'd5, 4'b0000}) begin
      n_fail++; $display("FAIL cmd8_status: cpl=%b fsm=%0d errs=%b want 1/5/0000", ifc.cmd_complete, ifc.cmd_fsm,
                         {ifc.cmd_timeout_err, ifc.cmd_crc_err, ifc.cmd_end_err, ifc.cmd_index_err});
    end
    finish_ncc(b7, b8);
  endtask

  task automatic test_resp_errors();
    logic b7, b8;
    run_r1(6'd8, 32'h0000_01AA, 1'b1, 1'b1, 48'h08000001AA15, 2);
    n_checks++;
    if ({ifc.cmd_crc_err, ifc.cmd_end_err, ifc.cmd_index_err, ifc.resp_crc} !== {3'b100, 7'h0A}) begin
      n_fail++; $display("FAIL crc_err_on: errs=%b crc=%h want 100/0a",
                         {ifc.cmd_crc_err, ifc.cmd_end_err, ifc.cmd_index_err}, ifc.resp_crc);
    end
    finish_ncc(b7, b8);
    run_r1(6'd8, 32'h0000_01AA, 1'b1, 1'b0, 48'h08000001AA15, 2);
    n_checks++;
    if (ifc.cmd_crc_err !== 1'b0) begin
      n_fail++; $display("FAIL crc_err_off: got %b want 0", ifc.cmd_crc_err);
    end
    finish_ncc(b7, b8);
    run_r1(6'd8, 32'h0000_01AA, 1'b1, 1'b0, 48'h09000001AA13, 1);
    n_checks++;
    if ({ifc.cmd_index_err, ifc.cmd_crc_err, ifc.resp_index} !== {2'b10, 6'd9}) begin
      n_fail++; $display("FAIL index_err: ierr=%b cerr=%b idx=%0d want 1/0/9",
                         ifc.cmd_index_err, ifc.cmd_crc_err, ifc.resp_index);
    end
    finish_ncc(b7, b8);
  endtask

  task automatic test_timeout();
    logic b7, b8;
    start_cmd(6'd8, 32'h0000_01AA, 2'd2, 1'b1, 1'b1);
    n_checks++;
    if (ifc.cmd_index_err !== 1'b0) begin
      n_fail++; $display("FAIL start_clears_flags: got %b want 0", ifc.cmd_index_err);
    end
    do_tx(-1);
    for (int i = 0; i < 63; i++) rx_bit(1'b1);
    n_checks++;
    if ({ifc.cmd_timeout_err, ifc.cmd_complete, ifc.cmd_fsm} !== {2'b00, 4'd2}) begin
      n_fail++; $display("FAIL timeout_early: tout=%b cpl=%b fsm=%0d want 0/0/2",
                         ifc.cmd_timeout_err, ifc.cmd_complete, ifc.cmd_fsm);
    end
    rx_bit(1'b1);
    $display("txn: CMD8 no response tout=%b fsm=%0d", ifc.cmd_timeout_err, ifc.cmd_fsm);
    n_checks++;
    if ({ifc.cmd_timeout_err, ifc.cmd_complete, ifc.cmd_fsm} !== {2'b11, 4'd5}) begin
      n_fail++; $display("FAIL timeout_64: tout=%b cpl=%b fsm=%0d want 1/1/5",
                         ifc.cmd_timeout_err, ifc.cmd_complete, ifc.cmd_fsm);
    end
    n_checks++;
    if ({ifc.resp, ifc.resp_index} !== {120'h1AA, 6'd9}) begin
      n_fail++; $display("FAIL timeout_resp_kept: got %h/%0d want 1aa/9", ifc.resp, ifc.resp_index);
    end
    tick();
    n_checks++;
    if (ifc.cmd_complete !== 1'b0) begin
      n_fail++; $display("FAIL timeout_cpl_once: got %b want 0", ifc.cmd_complete);
    end
    finish_ncc(b7, b8);
  endtask

  task automatic test_r2();
    logic b7, b8;
    logic [119:0] field;
    logic [135:0] frame;
    field = 120'h00112233445566778899AABBCCDDEE;
    for (int pass = 0; pass < 2; pass++) begin
      frame = {2'b00, 6'h3F, field, crc7_bits(field), (pass == 0) ? 1'b1 : 1'b0};
      start_cmd(6'd2, 32'd0, 2'd1, 1'b1, 1'b1);
      do_tx(-1);
      card_send(frame, 136, 2);
      tick();
      $display("txn: CMD2 R2 resp=%h idx=%h err(c/e/i)=%b%b%b", ifc.resp, ifc.resp_index,
               ifc.cmd_crc_err, ifc.cmd_end_err, ifc.cmd_index_err);
      if (pass == 0) begin
        n_checks++;
        if ({ifc.resp, ifc.resp_index} !== {field, 6'h3F}) begin
          n_fail++; $display("FAIL r2_resp: got %h/%h want %h/3f", ifc.resp, ifc.resp_index, field);
        end
        n_checks++;
        if ({ifc.cmd_crc_err, ifc.cmd_end_err, ifc.cmd_index_err} !== 3'b000) begin
          n_fail++; $display("FAIL r2_errs: got %b want 000", {ifc.cmd_crc_err, ifc.cmd_end_err, ifc.cmd_index_err});
        end
      end else begin
        n_checks++;
        if ({ifc.cmd_crc_err, ifc.cmd_end_err, ifc.cmd_index_err} !== 3'b010) begin
          n_fail++; $display("FAIL r2_end_err: got %b want 010", {ifc.cmd_crc_err, ifc.cmd_end_err, ifc.cmd_index_err});
        end
      end
      finish_ncc(b7, b8);
    end
  endtask

  task automatic test_soft_reset();
    start_cmd(6'd8, 32'h0000_01AA, 2'd2, 1'b1, 1'b1);
    do_tx(-1);
    rx_bit(1'b1);
    rx_bit(1'b0);
    for (int i = 0; i < 10; i++) rx_bit(i[0]);
    card_bit = 1'b1;
    n_checks++;
    if (ifc.cmd_fsm !== 4'd3) begin
      n_fail++; $display("FAIL srst_in_rx: fsm=%0d want 3", ifc.cmd_fsm);
    end
    cmd_sd_rst = 1'b1;
    tick();
    cmd_sd_rst = 1'b0;
    $display("txn: soft reset mid-RX fsm=%0d", ifc.cmd_fsm);
    n_checks++;
    if ({ifc.cmd_fsm, ifc.pad_cmd_oe, ifc.cmd_busy, ifc.pad_cmd_o} !== {4'd0, 3'b001}) begin
      n_fail++; $display("FAIL srst_rx_idle: fsm=%0d oe=%b busy=%b o=%b want 0/0/0/1",
                         ifc.cmd_fsm, ifc.pad_cmd_oe, ifc.cmd_busy, ifc.pad_cmd_o);
    end
    run_r1(6'd8, 32'h0000_01AA, 1'b1, 1'b1, 48'h08000001AA15, 3);
    n_checks++;
    if (ifc.cmd_crc_err !== 1'b1) begin
      n_fail++; $display("FAIL srst_pre_flag: got %b want 1", ifc.cmd_crc_err);
    end
    cmd_sd_rst = 1'b1;
    tick();
    cmd_sd_rst = 1'b0;
    n_checks++;
    if ({ifc.cmd_crc_err, ifc.cmd_fsm, ifc.resp, ifc.resp_index, ifc.resp_crc} !== 138'd0) begin
      n_fail++; $display("FAIL srst_clears: crc_err=%b fsm=%0d resp=%h idx=%0d crc=%h want all 0",
                         ifc.cmd_crc_err, ifc.cmd_fsm, ifc.resp, ifc.resp_index, ifc.resp_crc);
    end
  endtask

  task automatic test_back_to_back();
    logic b7, b8;
    start_cmd(6'd0, 32'd0, 2'd0, 1'b0, 1'b0);
    do_tx(10);
    $display("txn: CMD0 with ignored start frame=%h", cap);
    n_checks++;
    if (cap !== 48'h400000000095) begin
      n_fail++; $display("FAIL ignored_start_frame: got %h want 400000000095", cap);
    end
    n_checks++;
    if ({ifc.cmd_fsm, ifc.cmd_complete} !== {4'd5, 1'b1}) begin
      n_fail++; $display("FAIL ignored_start_type: fsm=%0d cpl=%b want 5/1", ifc.cmd_fsm, ifc.cmd_complete);
    end
    finish_ncc(b7, b8);
    start_cmd(6'd8, 32'h0000_01AA, 2'd0, 1'b0, 1'b0);
    do_tx(-1);
    $display("txn: CMD8 back-to-back frame=%h", cap);
    n_checks++;
    if (cap !== 48'h48000001AA87) begin
      n_fail++; $display("FAIL b2b_frame: got %h want 48000001AA87", cap);
    end
    finish_ncc(b7, b8);
    n_checks++;
    if (ifc.cmd_busy !== 1'b0) begin
      n_fail++; $display("FAIL b2b_idle: busy=%b want 0", ifc.cmd_busy);
    end
  endtask

  initial begin
    ifc.tx_en = 1'b0;
    ifc.rx_en = 1'b0;
    ifc.cmd_start = 1'b0;
    ifc.cmd_index = '0;
    ifc.cmd_argument = '0;
    ifc.resp_type = '0;
    ifc.cmd_index_check = 1'b0;
    ifc.cmd_crc_check = 1'b0;
    repeat (3) tick();
    rstn = 1'b1;
    tick();
    test_reset();
    test_cmd0();
    test_cmd8();
    test_resp_errors();
    test_timeout();
    test_r2();
    test_soft_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
